// File: rtl/census_disparity_wta.sv
// Census stereo matcher: Hamming cost against MAX_DISP right-image candidates,
// then winner-take-all per left pixel over a two-stage pipeline.
module census_disparity_wta #(
    parameter int CODE_WIDTH = 8,
    parameter int MAX_DISP   = 16,
    parameter int DISP_WIDTH = 4,
    localparam int COST_WIDTH = $clog2(CODE_WIDTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic                  line_start,
    input  logic [CODE_WIDTH-1:0] left_code,
    input  logic [CODE_WIDTH-1:0] right_code,
    output logic                  out_valid,
    output logic [DISP_WIDTH-1:0] disparity,
    output logic [COST_WIDTH-1:0] min_cost
);

    function automatic logic [COST_WIDTH-1:0] popcount(input logic [CODE_WIDTH-1:0] x);
        logic [COST_WIDTH-1:0] n;
        n = '0;
        for (int i = 0; i < CODE_WIDTH; i++) n = n + COST_WIDTH'(x[i]);
        return n;
    endfunction

    logic [CODE_WIDTH-1:0] hist [MAX_DISP-1];
    logic [DISP_WIDTH-1:0] col;
    logic [DISP_WIDTH-1:0] cur_col;
    logic [CODE_WIDTH-1:0] cand [MAX_DISP];

    logic [COST_WIDTH-1:0] cost_p1 [MAX_DISP];
    logic [MAX_DISP-1:0]   elig_p1;
    logic                  vld_p1;

    logic [DISP_WIDTH-1:0] best_disp;
    logic [COST_WIDTH-1:0] best_cost;

    // Candidate d pairs left column x with right column x-d, taken before the history shifts.
    always_comb begin
        cur_col = line_start ? '0 : col;
        cand[0] = right_code;
        for (int d = 1; d < MAX_DISP; d++) cand[d] = hist[d-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < MAX_DISP - 1; k++) hist[k] <= '0;
            col <= '0;
        end else if (in_valid) begin
            hist[0] <= right_code;
            for (int k = 1; k < MAX_DISP - 1; k++) hist[k] <= hist[k-1];
            if (line_start)
                col <= DISP_WIDTH'(1);
            else if (col != DISP_WIDTH'(MAX_DISP - 1))
                col <= col + DISP_WIDTH'(1);
        end
    end

    // ---- stage p1: per-candidate Hamming cost and eligibility ----
    always_ff @(posedge clk) begin
        if (in_valid) begin
            for (int d = 0; d < MAX_DISP; d++) begin
                cost_p1[d] <= popcount(left_code ^ cand[d]);
                elig_p1[d] <= (DISP_WIDTH'(d) <= cur_col);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) vld_p1 <= 1'b0;
        else        vld_p1 <= in_valid;
    end

    // Strict less-than keeps the smallest disparity on ties; d=0 is always eligible.
    always_comb begin
        best_disp = '0;
        best_cost = cost_p1[0];
        for (int d = 1; d < MAX_DISP; d++) begin
            if (elig_p1[d] && (cost_p1[d] < best_cost)) begin
                best_disp = DISP_WIDTH'(d);
                best_cost = cost_p1[d];
            end
        end
    end

    // ---- stage p2: registered winner ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            disparity <= '0;
            min_cost  <= '0;
        end else begin
            out_valid <= vld_p1;
            if (vld_p1) begin
                disparity <= best_disp;
                min_cost  <= best_cost;
            end
        end
    end

endmodule
